// File: rtl/ldst_map_pkg.sv
// Address map, control-register bit positions and target decode shared by the
// load/store responder and its bench-facing users.
package ldst_map_pkg;

   localparam logic [15:0] RAM_BASE   = 16'h0000;
   localparam logic [15:0] ADDR_LEDR  = 16'h2000;
   localparam logic [15:0] ADDR_SW    = 16'h2002;
   localparam logic [15:0] ADDR_TIMER = 16'h2004;
   localparam logic [15:0] ADDR_CTRL  = 16'h2006;

   localparam int CTRL_EN   = 0;
   localparam int CTRL_WRAP = 1;

   typedef enum logic [2:0] {
      T_RAM,
      T_LEDR,
      T_SW,
      T_TIMER,
      T_CTRL,
      T_NONE
   } target_e;

   // Decode a word index (byte address with bit 0 dropped) into a target.
   // Words past the RAM top but below the register bank fall through to T_NONE.
   function automatic target_e decode_target(input logic [14:0] word,
                                             input int unsigned ram_words);
      target_e t;
      t = T_NONE;
      if ((32'(word) - 32'(RAM_BASE[15:1])) < ram_words) begin
         t = T_RAM;
      end else if (word == ADDR_LEDR[15:1]) begin
         t = T_LEDR;
      end else if (word == ADDR_SW[15:1]) begin
         t = T_SW;
      end else if (word == ADDR_TIMER[15:1]) begin
         t = T_TIMER;
      end else if (word == ADDR_CTRL[15:1]) begin
         t = T_CTRL;
      end
      return t;
   endfunction

endpackage

// File: rtl/ldst_ram.sv
// Single-port 16-bit word RAM with a registered read port. The read register
// only loads on a read cycle, so it holds its value across writes and idles.
module ldst_ram #(
   parameter int WORDS = 4096,
   parameter int AW    = 12
) (
   input  logic          clk,
   input  logic          we,
   input  logic          re,
   input  logic [AW-1:0] addr,
   input  logic [15:0]   wdata,
   output logic [15:0]   rdata
);

   logic [15:0] mem [WORDS];
   logic [15:0] rdata_q;

   // Write has priority; a read only updates the output register when no write is present.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end else if (re) begin
         rdata_q <= mem[addr];
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/ldst_responder.sv
// Load/store target: decodes CPU requests into the data RAM and a small
// register bank (LEDR, synchronised switches, free-running timer, control).
// Reads complete one cycle after the request; writes land at the request edge.
module ldst_responder
   import ldst_map_pkg::*;
#(
   parameter int RAM_WORDS = 4096,
   parameter int SW_WIDTH  = 10,
   parameter int LED_WIDTH = 10
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [15:0]          i_ldst_addr,
   input  logic                 i_ldst_rd,
   input  logic                 i_ldst_wr,
   input  logic [15:0]          i_ldst_wrdata,
   output logic [15:0]          o_ldst_rddata,
   input  logic [SW_WIDTH-1:0]  i_sw,
   output logic [LED_WIDTH-1:0] o_ledr,
   output logic                 o_timer_wrap
);

   localparam int RAM_AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

   logic [14:0]          word_idx;
   logic                 unused_addr_lsb;
   target_e              req_target;
   logic                 rd_fire;
   logic                 wr_fire;
   logic                 ram_we;
   logic                 ram_re;
   logic [15:0]          ram_rdata;
   logic [15:0]          reg_rd_val;

   logic [LED_WIDTH-1:0] ledr_q, ledr_d;
   logic [15:0]          timer_q, timer_d;
   logic                 en_q, en_d;
   logic                 wrap_q, wrap_d;
   logic [SW_WIDTH-1:0]  sw_sync1_q, sw_sync1_d;
   logic [SW_WIDTH-1:0]  sw_sync2_q, sw_sync2_d;
   logic [15:0]          reg_rdata_q, reg_rdata_d;
   target_e              rd_src_q, rd_src_d;

   assign word_idx        = i_ldst_addr[15:1];
   assign unused_addr_lsb = i_ldst_addr[0];

   // Decode the request; a read paired with a write is dropped, and nothing fires in reset.
   always_comb begin
      req_target = decode_target(word_idx, RAM_WORDS);
      rd_fire    = reset & i_ldst_rd & ~i_ldst_wr;
      wr_fire    = reset & i_ldst_wr;
      ram_we     = wr_fire && (req_target == T_RAM);
      ram_re     = rd_fire && (req_target == T_RAM);
   end

   ldst_ram #(
      .WORDS (RAM_WORDS),
      .AW    (RAM_AW)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .re    (ram_re),
      .addr  (word_idx[RAM_AW-1:0]),
      .wdata (i_ldst_wrdata),
      .rdata (ram_rdata)
   );

   // Register-bank read value, taken from current state before this edge's updates.
   always_comb begin
      reg_rd_val = '0;
      case (req_target)
         T_LEDR:  reg_rd_val = 16'(ledr_q);
         T_SW:    reg_rd_val = 16'(sw_sync2_q);
         T_TIMER: reg_rd_val = timer_q;
         T_CTRL: begin
            reg_rd_val[CTRL_EN]   = en_q;
            reg_rd_val[CTRL_WRAP] = wrap_q;
         end
         default: reg_rd_val = '0;
      endcase
   end

   // Next-state for registers, timer, wrap flag, switch synchroniser and read steering.
   always_comb begin
      ledr_d      = ledr_q;
      timer_d     = timer_q;
      en_d        = en_q;
      wrap_d      = wrap_q;
      sw_sync1_d  = i_sw;
      sw_sync2_d  = sw_sync1_q;
      reg_rdata_d = reg_rdata_q;
      rd_src_d    = rd_src_q;

      if (wr_fire && (req_target == T_LEDR)) begin
         ledr_d = i_ldst_wrdata[LED_WIDTH-1:0];
      end

      if (wr_fire && (req_target == T_CTRL)) begin
         en_d = i_ldst_wrdata[CTRL_EN];
         if (i_ldst_wrdata[CTRL_WRAP]) begin
            wrap_d = 1'b0;
         end
      end

      if (wr_fire && (req_target == T_TIMER)) begin
         timer_d = i_ldst_wrdata;
      end else if (en_q) begin
         timer_d = timer_q + 16'd1;
         if (timer_q == 16'hFFFF) begin
            wrap_d = 1'b1;
         end
      end

      if (rd_fire) begin
         rd_src_d = req_target;
         if (req_target != T_RAM) begin
            reg_rdata_d = reg_rd_val;
         end
      end
   end

   // State registers with synchronous active-low reset; RAM contents are left alone.
   always_ff @(posedge clk) begin
      if (!reset) begin
         ledr_q      <= '0;
         timer_q     <= '0;
         en_q        <= 1'b0;
         wrap_q      <= 1'b0;
         sw_sync1_q  <= '0;
         sw_sync2_q  <= '0;
         reg_rdata_q <= '0;
         rd_src_q    <= T_NONE;
      end else begin
         ledr_q      <= ledr_d;
         timer_q     <= timer_d;
         en_q        <= en_d;
         wrap_q      <= wrap_d;
         sw_sync1_q  <= sw_sync1_d;
         sw_sync2_q  <= sw_sync2_d;
         reg_rdata_q <= reg_rdata_d;
         rd_src_q    <= rd_src_d;
      end
   end

   assign o_ldst_rddata = (rd_src_q == T_RAM) ? ram_rdata : reg_rdata_q;
   assign o_ledr        = ledr_q;
   assign o_timer_wrap  = wrap_q;

endmodule
